mem_boot_ctrl: RTL and testbench

MEM_BOOT_CTRL -- requirements
Module: mem_boot_ctrl

---
 rtl/mem_boot_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_boot_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_boot_ctrl.sv
// Boot loader: streams an image into instruction/data memories, holds the core in
// reset for a fixed settle time, then runs it for a bounded (or unbounded) cycle count.
module mem_boot_ctrl #(
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned NUM_MEM      = 2,
  parameter int unsigned SEL_W        = 1,
  parameter int unsigned HOLD_CYCLES  = 10,
  parameter int unsigned CYCLE_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CYCLE_W-1:0]      run_cycles,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_SIZE-1:0]    s_data,
  input  logic [SEL_W-1:0]        s_sel,
  input  logic                    s_last,
  output logic [NUM_MEM-1:0]      mem_we,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0]    mem_wdata,
  output logic                    core_reset_n,
  output logic                    core_run,
  output logic                    busy,
  output logic                    done,
  output logic                    sel_err,
  output logic [CYCLE_W-1:0]      cycle_count
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [ADDRESS_SIZE-1:0] addr_cnt [NUM_MEM];
  logic [CYCLE_W-1:0]      run_len;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [NUM_MEM-1:0]      sel_oh;
  logic [ADDRESS_SIZE-1:0] sel_addr;
  logic [CYCLE_W-1:0]      count_inc;
  logic                    sel_ok;
  logic                    accept;
  logic                    enter_load;
  logic                    hold_end;
  logic                    run_end;

  // Decode the beat's target memory without indexing by an out-of-range select
  always_comb begin
    sel_oh   = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_MEM; i++) begin
      if (s_sel == SEL_W'(i)) begin
        sel_oh[i] = 1'b1;
        sel_addr  = addr_cnt[i];
      end
    end
  end

  assign sel_ok     = |sel_oh;
  assign accept     = (state == LOAD) && s_valid && !abort;
  assign enter_load = ((state == IDLE) || (state == DONE)) && start && !abort;
  assign hold_end   = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
  assign count_inc  = (&cycle_count) ? cycle_count : cycle_count + CYCLE_W'(1);
  assign run_end    = (run_len != '0) && (count_inc == run_len);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state; abort overrides everything
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_nx = LOAD;
        LOAD:       if (accept && s_last) state_nx = HOLD;
        HOLD:       if (hold_end) state_nx = RUN;
        RUN:        if (run_end) state_nx = DONE;
        default:    state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_MEM; i++) addr_cnt[i] <= '0;
      run_len      <= '0;
      hold_cnt     <= '0;
      mem_we       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      sel_err      <= 1'b0;
      cycle_count  <= '0;
      s_ready      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      core_reset_n <= 1'b0;
      core_run     <= 1'b0;
    end else begin
      mem_we <= '0;
      if (enter_load) begin
        for (int i = 0; i < NUM_MEM; i++) addr_cnt[i] <= '0;
        cycle_count <= '0;
        sel_err     <= 1'b0;
        run_len     <= run_cycles;
      end
      if (accept) begin
        if (sel_ok) begin
          mem_we    <= sel_oh;
          mem_addr  <= sel_addr;
          mem_wdata <= s_data;
          for (int i = 0; i < NUM_MEM; i++) begin
            if (sel_oh[i]) addr_cnt[i] <= addr_cnt[i] + ADDRESS_SIZE'(1);
          end
        end else begin
          sel_err <= 1'b1;
        end
      end
      hold_cnt <= ((state == HOLD) && (state_nx == HOLD)) ? hold_cnt + HOLD_W'(1) : '0;
      if ((state == RUN) && !abort) cycle_count <= count_inc;
      // Status flags are registered copies of the upcoming state
      s_ready      <= (state_nx == LOAD);
      busy         <= (state_nx == LOAD) || (state_nx == HOLD) || (state_nx == RUN);
      done         <= (state_nx == DONE);
      core_reset_n <= (state_nx == RUN) || (state_nx == DONE);
      core_run     <= (state_nx == RUN);
    end
  end

endmodule

// File: tb/tb_mem_boot_ctrl.sv
// Bench for mem_boot_ctrl: random boot sessions checked against a queue-based model
// of expected memory writes plus phase-length and status expectations.
module tb_mem_boot_ctrl;

  localparam int HOLD = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort, s_valid, s_last;
  logic [3:0]  run_cycles;
  logic        s_ready;
  logic [31:0] s_data;
  logic [1:0]  s_sel;
  logic [1:0]  mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset_n, core_run, busy, done, sel_err;
  logic [3:0]  cycle_count;

  mem_boot_ctrl #(
    .DATA_SIZE(32), .ADDRESS_SIZE(4), .NUM_MEM(2), .SEL_W(2),
    .HOLD_CYCLES(HOLD), .CYCLE_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .run_cycles(run_cycles), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sel(s_sel), .s_last(s_last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_reset_n(core_reset_n),
    .core_run(core_run), .busy(busy), .done(done), .sel_err(sel_err),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mem;
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  m_addr[2];
  int  m_err;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every write pulse must match the next expected write, in order
  always @(posedge clk) begin
    #1;
    if (reset_n && mem_we != 2'b00) begin
      if (exp_q.size() == 0) chk("spurious_we", int'(mem_we), 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("we_sel", int'(mem_we), 1 << mon_e.mem);
        chk("we_addr", int'(mem_addr), mon_e.addr);
        chk("we_data", int'(mem_wdata), mon_e.data);
      end
    end
  end

  task automatic reset_check(input string tag);
    chk({tag, "_ready"}, int'(s_ready), 0);
    chk({tag, "_we"}, int'(mem_we), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_wdata"}, int'(mem_wdata), 0);
    chk({tag, "_core_rst_n"}, int'(core_reset_n), 0);
    chk({tag, "_core_run"}, int'(core_run), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_sel_err"}, int'(sel_err), 0);
    chk({tag, "_cycles"}, int'(cycle_count), 0);
  endtask

  task automatic do_start(input int run);
    start = 1'b1;
    run_cycles = 4'(run);
    step();
    start = 1'b0;
    run_cycles = 4'($urandom);
    m_addr[0] = 0;
    m_addr[1] = 0;
    m_err = 0;
    chk("load_ready", int'(s_ready), 1);
    chk("load_busy", int'(busy), 1);
    chk("load_done", int'(done), 0);
    chk("load_core_rst_n", int'(core_reset_n), 0);
    chk("load_cycles", int'(cycle_count), 0);
    chk("load_sel_err", int'(sel_err), 0);
  endtask

  task automatic send_beat(input int sel, input int data, input bit last);
    repeat ($urandom_range(0, 2)) begin
      s_valid = 1'b0;
      s_sel   = 2'($urandom);
      s_data  = $urandom;
      s_last  = 1'($urandom);
      step();
    end
    s_valid = 1'b1;
    s_sel   = 2'(sel);
    s_data  = data;
    s_last  = last;
    if (sel < 2) begin
      exp_q.push_back('{sel, m_addr[sel], data});
      m_addr[sel] = (m_addr[sel] + 1) % 16;
    end else begin
      m_err = 1;
    end
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("beat_sel_err", int'(sel_err), m_err);
  endtask

  // Counts reset-hold cycles; a stray start mid-hold must be ignored
  task automatic wait_hold();
    int n = 0;
    chk("hold_ready", int'(s_ready), 0);
    while (!core_reset_n && n < 50) begin
      start = (n == 3);
      step();
      n++;
    end
    start = 1'b0;
    chk("hold_len", n, HOLD);
    chk("run_core_run", int'(core_run), 1);
    chk("run_cycles0", int'(cycle_count), 0);
    chk("pending_writes", exp_q.size(), 0);
  endtask

  task automatic run_and_done(input int run);
    int n = 0;
    while (core_run && n < 40) begin
      chk("run_count", int'(cycle_count), n);
      step();
      n++;
    end
    chk("run_len", n, run);
    chk("done_flag", int'(done), 1);
    chk("done_cycles", int'(cycle_count), run);
    chk("done_core_rst_n", int'(core_reset_n), 1);
    chk("done_busy", int'(busy), 0);
    chk("done_sel_err", int'(sel_err), m_err);
    repeat (2) step();
    chk("done_hold", int'(done), 1);
    chk("done_cycles_hold", int'(cycle_count), run);
  endtask

  task automatic session(input int nb, input int bad_pct, input int run, input int fixed_sel);
    int sel;
    do_start(run);
    for (int b = 0; b < nb; b++) begin
      if (fixed_sel >= 0) sel = fixed_sel;
      else if ($urandom_range(0, 99) < bad_pct) sel = $urandom_range(2, 3);
      else sel = $urandom_range(0, 1);
      send_beat(sel, int'($urandom), b == nb - 1);
    end
    wait_hold();
    run_and_done(run);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    run_cycles = '0; s_data = '0; s_sel = '0;
    repeat (3) step();
    reset_check("rst");
    reset_n = 1'b1;
    repeat (2) step();
    chk("idle_busy", int'(busy), 0);

    // Four sel-0 words A0..A3, fifteen-cycle run
    do_start(15);
    for (int i = 0; i < 4; i++) send_beat(0, 32'hA0 + i, i == 3);
    wait_hold();
    run_and_done(15);

    // Interleaved memories, then a restart from DONE with a bad select
    do_start(3);
    for (int i = 0; i < 4; i++) send_beat(i % 2, int'($urandom), i == 3);
    wait_hold();
    run_and_done(3);
    do_start(1);
    send_beat(0, 32'h11, 1'b0);
    send_beat(3, 32'h22, 1'b0);
    send_beat(0, 32'h33, 1'b1);
    wait_hold();
    run_and_done(1);

    // Address counter wrap
    session(18, 0, 2, 0);

    // Free run saturates, then abort at cycle 7 of a free run
    do_start(0);
    send_beat(1, int'($urandom), 1'b1);
    wait_hold();
    repeat (20) step();
    chk("sat_cycles", int'(cycle_count), 15);
    chk("sat_running", int'(core_run), 1);
    chk("sat_done", int'(done), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    do_start(0);
    send_beat(0, int'($urandom), 1'b1);
    wait_hold();
    repeat (7) step();
    chk("abort_pre_cycles", int'(cycle_count), 7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_core_rst_n", int'(core_reset_n), 0);
    chk("abort_core_run", int'(core_run), 0);
    chk("abort_cycles", int'(cycle_count), 7);
    repeat (3) step();
    chk("abort_cycles_hold", int'(cycle_count), 7);

    // Abort squashes a beat offered on the same cycle; abort beats start
    do_start(5);
    send_beat(1, int'($urandom), 1'b0);
    s_valid = 1'b1; s_sel = 2'd0; s_data = 32'hDEAD; s_last = 1'b1; abort = 1'b1;
    step();
    s_valid = 1'b0; s_last = 1'b0; abort = 1'b0;
    chk("abort_load_ready", int'(s_ready), 0);
    chk("abort_load_busy", int'(busy), 0);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("abort_over_start", int'(busy), 0);
    step();

    // Asynchronous reset mid-load
    do_start(4);
    send_beat(0, int'($urandom), 1'b0);
    send_beat(0, int'($urandom), 1'b0);
    s_valid = 1'b1; s_sel = 2'd0; s_data = 32'hBEEF;
    #2 reset_n = 1'b0;
    #1 reset_check("async_rst");
    repeat (2) step();
    s_valid = 1'b0;
    reset_n = 1'b1;
    repeat (3) step();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_ready", int'(s_ready), 0);

    // Random sessions
    for (int r = 0; r < 15; r++)
      session($urandom_range(1, 8), 15, $urandom_range(1, 15), -1);

    repeat (3) step();
    chk("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
